rob_commit_unit: RTL

- 16-entry circular reorder buffer between issue and the architectural register file.
- Allocates one entry per issued instruction and captures results from the common data bus (CDB).
- Retires at most one entry per cycle in program order, driving the register-file write port, the store-commit strobe and the mispredict flush.
- Also answers the issue stage's operand lookups by ROB tag.

---
 rtl/rob_commit_if.sv | 49 ++++
 rtl/rob_commit_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rob_commit_if.sv
// Issue, operand-query, CDB and retire signals of the reorder buffer.
// master = issue/CDB side, slave = the ROB itself.
interface rob_commit_if #(
   parameter int TAG_W  = 4,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);
   logic              issue_valid;
   logic [REG_W-1:0]  issue_dest;
   logic              issue_is_branch;
   logic              issue_is_store;
   logic              issue_pred_taken;
   logic              rob_full;
   logic [TAG_W-1:0]  rob_tail;
   logic [TAG_W-1:0]  query1_tag;
   logic [TAG_W-1:0]  query2_tag;
   logic              query1_ready;
   logic              query2_ready;
   logic [DATA_W-1:0] query1_data;
   logic [DATA_W-1:0] query2_data;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic              cdb_taken;
   logic [DATA_W-1:0] cdb_target;
   logic              has_from_rob;
   logic [REG_W-1:0]  dest_reg_num;
   logic [DATA_W-1:0] in_reg_data;
   logic              commit_store;
   logic [TAG_W-1:0]  commit_store_tag;
   logic              has_misbranch;
   logic [DATA_W-1:0] redirect_pc;

   modport master (
      output issue_valid, issue_dest, issue_is_branch, issue_is_store, issue_pred_taken,
      output query1_tag, query2_tag, cdb_valid, cdb_tag, cdb_data, cdb_taken, cdb_target,
      input  rob_full, rob_tail, query1_ready, query2_ready, query1_data, query2_data,
      input  has_from_rob, dest_reg_num, in_reg_data, commit_store, commit_store_tag,
      input  has_misbranch, redirect_pc
   );

   modport slave (
      input  issue_valid, issue_dest, issue_is_branch, issue_is_store, issue_pred_taken,
      input  query1_tag, query2_tag, cdb_valid, cdb_tag, cdb_data, cdb_taken, cdb_target,
      output rob_full, rob_tail, query1_ready, query2_ready, query1_data, query2_data,
      output has_from_rob, dest_reg_num, in_reg_data, commit_store, commit_store_tag,
      output has_misbranch, redirect_pc
   );
endinterface

// File: rtl/rob_commit_unit.sv
// 16-entry circular reorder buffer: in-order retire of one entry per cycle, 1-cycle min CDB-to-commit.
// Issue is held off by rob_full (full, or a mispredict flush in progress); rdy=0 freezes all state.
module rob_commit_unit #(
   parameter int DEPTH  = 16,
   parameter int TAG_W  = 4,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input logic         clk,
   input logic         rst,
   input logic         rdy,
   rob_commit_if.slave rob
);
   typedef struct packed {
      logic              valid;
      logic              ready;
      logic              is_branch;
      logic              is_store;
      logic              pred_taken;
      logic              taken;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] target;
   } entry_t;

   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

   entry_t            ent [DEPTH];
   logic [TAG_W-1:0]  head;
   logic [TAG_W-1:0]  tail;
   logic [TAG_W:0]    count;
   logic              flush_pending;
   logic              has_from_rob;
   logic [REG_W-1:0]  dest_reg_num;
   logic [DATA_W-1:0] in_reg_data;
   logic              commit_store;
   logic [TAG_W-1:0]  commit_store_tag;
   logic              has_misbranch;
   logic [DATA_W-1:0] redirect_pc;
   logic              full;
   logic              do_alloc;
   logic              do_commit;
   entry_t            hd;

   assign hd        = ent[head];
   assign full      = (count == FULL_CNT) || flush_pending || has_misbranch;
   assign do_alloc  = rob.issue_valid && !full;
   assign do_commit = (count != '0) && hd.valid && hd.ready && !flush_pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
         head             <= '0;
         tail             <= '0;
         count            <= '0;
         flush_pending    <= 1'b0;
         has_from_rob     <= 1'b0;
         dest_reg_num     <= '0;
         in_reg_data      <= '0;
         commit_store     <= 1'b0;
         commit_store_tag <= '0;
         has_misbranch    <= 1'b0;
         redirect_pc      <= '0;
      end else if (!rdy) begin
         has_from_rob  <= 1'b0;
         commit_store  <= 1'b0;
         has_misbranch <= 1'b0;
      end else begin
         has_from_rob  <= 1'b0;
         commit_store  <= 1'b0;
         has_misbranch <= 1'b0;
         if (flush_pending) begin
            // The link write went out on the previous edge, so the flush never overlaps it.
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            flush_pending <= 1'b0;
            has_misbranch <= 1'b1;
         end else begin
            if (rob.cdb_valid && ent[rob.cdb_tag].valid) begin
               ent[rob.cdb_tag].ready  <= 1'b1;
               ent[rob.cdb_tag].data   <= rob.cdb_data;
               ent[rob.cdb_tag].taken  <= rob.cdb_taken;
               ent[rob.cdb_tag].target <= rob.cdb_target;
            end
            if (do_alloc) begin
               ent[tail].valid      <= 1'b1;
               ent[tail].ready      <= 1'b0;
               ent[tail].is_branch  <= rob.issue_is_branch;
               ent[tail].is_store   <= rob.issue_is_store;
               ent[tail].pred_taken <= rob.issue_pred_taken;
               ent[tail].taken      <= 1'b0;
               ent[tail].dest       <= rob.issue_dest;
               ent[tail].data       <= '0;
               ent[tail].target     <= '0;
               tail                 <= tail + 1'b1;
            end
            if (do_commit) begin
               ent[head] <= '0;
               head      <= head + 1'b1;
               if (hd.dest != '0) begin
                  has_from_rob <= 1'b1;
                  dest_reg_num <= hd.dest;
                  in_reg_data  <= hd.data;
               end
               if (hd.is_store) begin
                  commit_store     <= 1'b1;
                  commit_store_tag <= head;
               end
               if (hd.is_branch && (hd.taken != hd.pred_taken)) begin
                  flush_pending <= 1'b1;
                  redirect_pc   <= hd.target;
               end
            end
            case ({do_alloc, do_commit})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

   // A same-cycle CDB broadcast beats the stored entry so issue sees results a cycle early.
   always_comb begin
      rob.query1_ready = 1'b0;
      rob.query1_data  = '0;
      rob.query2_ready = 1'b0;
      rob.query2_data  = '0;
      if (rob.cdb_valid && (rob.cdb_tag == rob.query1_tag)) begin
         rob.query1_ready = 1'b1;
         rob.query1_data  = rob.cdb_data;
      end else if (ent[rob.query1_tag].ready) begin
         rob.query1_ready = 1'b1;
         rob.query1_data  = ent[rob.query1_tag].data;
      end
      if (rob.cdb_valid && (rob.cdb_tag == rob.query2_tag)) begin
         rob.query2_ready = 1'b1;
         rob.query2_data  = rob.cdb_data;
      end else if (ent[rob.query2_tag].ready) begin
         rob.query2_ready = 1'b1;
         rob.query2_data  = ent[rob.query2_tag].data;
      end
   end

   assign rob.rob_full         = full;
   assign rob.rob_tail         = tail;
   assign rob.has_from_rob     = has_from_rob;
   assign rob.dest_reg_num     = dest_reg_num;
   assign rob.in_reg_data      = in_reg_data;
   assign rob.commit_store     = commit_store;
   assign rob.commit_store_tag = commit_store_tag;
   assign rob.has_misbranch    = has_misbranch;
   assign rob.redirect_pc      = redirect_pc;
endmodule
